// File: rtl/bp_me_lce_txn_monitor.sv
// bp_me_lce_txn_monitor
//
// Passive transaction monitor for the LCE request and LCE command channels of
// num_lce_p LCEs. Each accepted request allocates an entry in that LCE's
// tracking table. A fill command with a matching block address retires the
// entry. The monitor keeps saturating request/fill counters, the worst-case
// miss latency seen on any LCE, and sticky timeout/overflow/unmatched flags.
// It never drives anything back into the network.
//
// Ports:
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   clear_i                synchronous clear of counters, max latency and
//                          sticky errors (tables are kept)
//   req_v_i/req_ready_i    per-LCE request handshake
//   req_addr_i             per-LCE request address, LCE i at slice i
//   cmd_v_i/cmd_yumi_i     per-LCE inbound command handshake
//   cmd_addr_i             per-LCE command address
//   cmd_fill_i             command completes a miss
//   req_count_o            accepted requests per LCE (saturating)
//   fill_count_o           matched fills per LCE (saturating)
//   outstanding_o          valid table entries per LCE
//   max_latency_o          largest matched miss latency over all LCEs
//   err_timeout_o          sticky: an entry aged to the timeout threshold
//   err_overflow_o         sticky: request accepted while the table was full
//   err_unmatched_o        sticky: fill with no matching entry

module bp_me_lce_txn_monitor #(
  parameter int num_lce_p           = 4,
  parameter int paddr_width_p       = 40,
  parameter int block_offset_bits_p = 6,
  parameter int max_outstanding_p   = 4,
  parameter int timeout_cycles_p    = 1024,
  parameter int cnt_width_p         = 32
) (
  input  logic                                                clk_i,
  input  logic                                                reset_n_i,
  input  logic                                                clear_i,
  input  logic [num_lce_p-1:0]                                req_v_i,
  input  logic [num_lce_p-1:0]                                req_ready_i,
  input  logic [num_lce_p*paddr_width_p-1:0]                  req_addr_i,
  input  logic [num_lce_p-1:0]                                cmd_v_i,
  input  logic [num_lce_p-1:0]                                cmd_yumi_i,
  input  logic [num_lce_p*paddr_width_p-1:0]                  cmd_addr_i,
  input  logic [num_lce_p-1:0]                                cmd_fill_i,
  output logic [num_lce_p*cnt_width_p-1:0]                    req_count_o,
  output logic [num_lce_p*cnt_width_p-1:0]                    fill_count_o,
  output logic [num_lce_p*$clog2(max_outstanding_p+1)-1:0]    outstanding_o,
  output logic [cnt_width_p-1:0]                              max_latency_o,
  output logic [num_lce_p-1:0]                                err_timeout_o,
  output logic [num_lce_p-1:0]                                err_overflow_o,
  output logic [num_lce_p-1:0]                                err_unmatched_o
);

  localparam int baddr_w_lp = paddr_width_p - block_offset_bits_p;
  localparam int age_w_lp   = $clog2(timeout_cycles_p + 1);
  localparam int out_w_lp   = $clog2(max_outstanding_p + 1);

  localparam logic [age_w_lp-1:0]    age_max_lp = age_w_lp'(timeout_cycles_p);
  localparam logic [age_w_lp-1:0]    age_to_lp  = age_w_lp'(timeout_cycles_p - 1);
  localparam logic [cnt_width_p-1:0] lat_max_lp = cnt_width_p'(timeout_cycles_p);

  // Tracking tables
  logic [num_lce_p-1:0][max_outstanding_p-1:0]                 valid_q, valid_d;
  logic [num_lce_p-1:0][max_outstanding_p-1:0][baddr_w_lp-1:0] baddr_q, baddr_d;
  logic [num_lce_p-1:0][max_outstanding_p-1:0][age_w_lp-1:0]   age_q, age_d;

  // Statistics and flags
  logic [num_lce_p-1:0][cnt_width_p-1:0] req_cnt_q, req_cnt_d;
  logic [num_lce_p-1:0][cnt_width_p-1:0] fill_cnt_q, fill_cnt_d;
  logic [num_lce_p-1:0][out_w_lp-1:0]    out_q, out_d;
  logic [cnt_width_p-1:0]                max_lat_q, max_lat_d;
  logic [num_lce_p-1:0]                  err_to_q, err_to_d;
  logic [num_lce_p-1:0]                  err_ov_q, err_ov_d;
  logic [num_lce_p-1:0]                  err_un_q, err_un_d;

  // Per-LCE scratch reused on every loop iteration
  logic                   req_acc, fill_acc, hit, alloc_done;
  logic [baddr_w_lp-1:0]  req_baddr, cmd_baddr;
  logic [cnt_width_p-1:0] lat;

  // The block offset bits never take part in matching.
  logic [num_lce_p-1:0] unused_req_offset, unused_cmd_offset;
  for (genvar g = 0; g < num_lce_p; g++) begin : g_unused
    assign unused_req_offset[g] = ^req_addr_i[g*paddr_width_p +: block_offset_bits_p];
    assign unused_cmd_offset[g] = ^cmd_addr_i[g*paddr_width_p +: block_offset_bits_p];
  end

  // All lookups (fill match, free-slot search, timeout detection) use the
  // pre-edge table. A same-cycle request is therefore never matched by a
  // same-cycle fill, and a slot freed by a fill is reusable only next cycle.
  always_comb begin
    valid_d    = valid_q;
    baddr_d    = baddr_q;
    age_d      = age_q;
    req_cnt_d  = req_cnt_q;
    fill_cnt_d = fill_cnt_q;
    out_d      = out_q;
    max_lat_d  = max_lat_q;
    err_to_d   = err_to_q;
    err_ov_d   = err_ov_q;
    err_un_d   = err_un_q;
    req_acc    = 1'b0;
    fill_acc   = 1'b0;
    hit        = 1'b0;
    alloc_done = 1'b0;
    req_baddr  = '0;
    cmd_baddr  = '0;
    lat        = '0;

    for (int i = 0; i < num_lce_p; i++) begin
      req_acc    = req_v_i[i] & req_ready_i[i];
      fill_acc   = cmd_v_i[i] & cmd_yumi_i[i] & cmd_fill_i[i];
      req_baddr  = req_addr_i[i*paddr_width_p + block_offset_bits_p +: baddr_w_lp];
      cmd_baddr  = cmd_addr_i[i*paddr_width_p + block_offset_bits_p +: baddr_w_lp];
      hit        = 1'b0;
      alloc_done = 1'b0;
      lat        = '0;

      for (int j = 0; j < max_outstanding_p; j++) begin
        if (valid_q[i][j]) begin
          if (age_q[i][j] != age_max_lp)
            age_d[i][j] = age_q[i][j] + age_w_lp'(1);
          if (age_q[i][j] == age_to_lp)
            err_to_d[i] = 1'b1;
        end

        // Lowest matching index retires first, which keeps duplicate block
        // addresses in allocation order. Latency is age+1 capped at the
        // timeout, so a saturated entry reports exactly the timeout value.
        if (fill_acc && !hit && valid_q[i][j] && (baddr_q[i][j] == cmd_baddr)) begin
          hit           = 1'b1;
          valid_d[i][j] = 1'b0;
          if (age_q[i][j] >= age_to_lp)
            lat = lat_max_lp;
          else
            lat = cnt_width_p'(age_q[i][j]) + cnt_width_p'(1);
        end

        if (req_acc && !alloc_done && !valid_q[i][j]) begin
          alloc_done    = 1'b1;
          valid_d[i][j] = 1'b1;
          baddr_d[i][j] = req_baddr;
          age_d[i][j]   = '0;
        end
      end

      if (req_acc) begin
        if (req_cnt_q[i] != '1)
          req_cnt_d[i] = req_cnt_q[i] + cnt_width_p'(1);
        if (!alloc_done)
          err_ov_d[i] = 1'b1;
      end

      if (fill_acc) begin
        if (hit) begin
          if (fill_cnt_q[i] != '1)
            fill_cnt_d[i] = fill_cnt_q[i] + cnt_width_p'(1);
          // Running max over the LCE loop: the largest candidate wins and a
          // tie with the stored value leaves it unchanged.
          if (lat > max_lat_d)
            max_lat_d = lat;
        end else begin
          err_un_d[i] = 1'b1;
        end
      end

      out_d[i] = '0;
      for (int j = 0; j < max_outstanding_p; j++)
        out_d[i] = out_d[i] + out_w_lp'(valid_d[i][j]);
    end

    // Clear beats any same-cycle event for statistics; tables keep updating.
    if (clear_i) begin
      req_cnt_d  = '0;
      fill_cnt_d = '0;
      max_lat_d  = '0;
      err_to_d   = '0;
      err_ov_d   = '0;
      err_un_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q    <= '0;
      baddr_q    <= '0;
      age_q      <= '0;
      req_cnt_q  <= '0;
      fill_cnt_q <= '0;
      out_q      <= '0;
      max_lat_q  <= '0;
      err_to_q   <= '0;
      err_ov_q   <= '0;
      err_un_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      baddr_q    <= baddr_d;
      age_q      <= age_d;
      req_cnt_q  <= req_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
      max_lat_q  <= max_lat_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
      err_un_q   <= err_un_d;
    end
  end

  assign req_count_o     = req_cnt_q;
  assign fill_count_o    = fill_cnt_q;
  assign outstanding_o   = out_q;
  assign max_latency_o   = max_lat_q;
  assign err_timeout_o   = err_to_q;
  assign err_overflow_o  = err_ov_q;
  assign err_unmatched_o = err_un_q;

endmodule

// File: tb/tb_bp_me_lce_txn_monitor.sv
// Testbench for bp_me_lce_txn_monitor. Each scenario task pushes the values it
// expects onto a scoreboard queue as it drives stimulus, then pops and
// compares them once the registered outputs have updated.

module tb_bp_me_lce_txn_monitor;

  localparam int NumLce  = 4;
  localparam int PaddrW  = 40;
  localparam int MaxOut  = 4;
  localparam int Timeout = 16;
  localparam int CntW    = 32;
  localparam int OutW    = 3;

  logic                     clk;
  logic                     reset_n;
  logic                     clear;
  logic [NumLce-1:0]        req_v, req_ready, cmd_v, cmd_yumi, cmd_fill;
  logic [NumLce*PaddrW-1:0] req_addr, cmd_addr;
  logic [NumLce*CntW-1:0]   req_count, fill_count;
  logic [NumLce*OutW-1:0]   outstanding;
  logic [CntW-1:0]          max_latency;
  logic [NumLce-1:0]        err_timeout, err_overflow, err_unmatched;

  int          checkCount;
  int          errorCount;
  logic [63:0] expQ[$];
  logic [63:0] expVal;
  logic [63:0] gotVal;

  bp_me_lce_txn_monitor #(
    .num_lce_p          (NumLce),
    .paddr_width_p      (PaddrW),
    .block_offset_bits_p(6),
    .max_outstanding_p  (MaxOut),
    .timeout_cycles_p   (Timeout),
    .cnt_width_p        (CntW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .clear_i        (clear),
    .req_v_i        (req_v),
    .req_ready_i    (req_ready),
    .req_addr_i     (req_addr),
    .cmd_v_i        (cmd_v),
    .cmd_yumi_i     (cmd_yumi),
    .cmd_addr_i     (cmd_addr),
    .cmd_fill_i     (cmd_fill),
    .req_count_o    (req_count),
    .fill_count_o   (fill_count),
    .outstanding_o  (outstanding),
    .max_latency_o  (max_latency),
    .err_timeout_o  (err_timeout),
    .err_overflow_o (err_overflow),
    .err_unmatched_o(err_unmatched)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-LCE views of the flattened output buses
  function automatic logic [63:0] reqCnt(input int i);
    return 64'(req_count[i*CntW +: CntW]);
  endfunction

  function automatic logic [63:0] fillCnt(input int i);
    return 64'(fill_count[i*CntW +: CntW]);
  endfunction

  function automatic logic [63:0] outst(input int i);
    return 64'(outstanding[i*OutW +: OutW]);
  endfunction

  // Error flags of one LCE packed as {timeout, overflow, unmatched}
  function automatic logic [63:0] errs(input int i);
    return 64'({err_timeout[i], err_overflow[i], err_unmatched[i]});
  endfunction

  // Advance to just after the next rising edge so outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_v     = '0;
    req_ready = '0;
    cmd_v     = '0;
    cmd_yumi  = '0;
    cmd_fill  = '0;
    clear     = 1'b0;
  endtask

  task automatic setReq(input int i, input logic [PaddrW-1:0] a);
    req_v[i]                    = 1'b1;
    req_ready[i]                = 1'b1;
    req_addr[i*PaddrW +: PaddrW] = a;
  endtask

  task automatic setCmd(input int i, input logic [PaddrW-1:0] a, input logic fill);
    cmd_v[i]                     = 1'b1;
    cmd_yumi[i]                  = 1'b1;
    cmd_fill[i]                  = fill;
    cmd_addr[i*PaddrW +: PaddrW] = a;
  endtask

  // Everything must read zero while reset is held
  task automatic test_reset();
    reset_n  = 1'b0;
    req_addr = '0;
    cmd_addr = '0;
    idle();
    for (int i = 0; i < NumLce; i++) begin
      expQ.push_back(64'd0);
      expQ.push_back(64'd0);
      expQ.push_back(64'd0);
      expQ.push_back(64'd0);
    end
    expQ.push_back(64'd0);
    tick();
    tick();
    for (int i = 0; i < NumLce; i++) begin
      expVal = expQ.pop_front(); gotVal = reqCnt(i); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL reset_req_count[%0d]: got %0d expected %0d", i, gotVal, expVal); end
      expVal = expQ.pop_front(); gotVal = fillCnt(i); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL reset_fill_count[%0d]: got %0d expected %0d", i, gotVal, expVal); end
      expVal = expQ.pop_front(); gotVal = outst(i); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL reset_outstanding[%0d]: got %0d expected %0d", i, gotVal, expVal); end
      expVal = expQ.pop_front(); gotVal = errs(i); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL reset_errors[%0d]: got %0h expected %0h", i, gotVal, expVal); end
    end
    expVal = expQ.pop_front(); gotVal = 64'(max_latency); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL reset_max_latency: got %0d expected %0d", gotVal, expVal); end
    reset_n = 1'b1;
    tick();
  endtask

  // One request on LCE0, filled five cycles after acceptance
  task automatic test_basic_fill();
    $display("[TB] basic fill on LCE0");
    expQ.push_back(64'd1);
    expQ.push_back(64'd1);
    setReq(0, 40'h80_0000_0040);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = reqCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_req_count: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_outstanding_after_req: got %0d expected %0d", gotVal, expVal); end
    repeat (4) tick();
    expQ.push_back(64'd1);
    expQ.push_back(64'd0);
    expQ.push_back(64'd5);
    expQ.push_back(64'd0);
    setCmd(0, 40'h80_0000_0040, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = fillCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_fill_count: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_outstanding_after_fill: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(max_latency); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_max_latency: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = errs(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL basic_errors: got %0h expected %0h", gotVal, expVal); end
  endtask

  // Non-fill command is ignored, fill into an empty table flags unmatched
  task automatic test_unmatched();
    $display("[TB] unmatched fill on LCE1");
    expQ.push_back(64'd0);
    setCmd(1, 40'h1000, 1'b0);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[1]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL nonfill_unmatched: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd1);
    expQ.push_back(64'd0);
    setCmd(1, 40'h1000, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[1]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL fill_unmatched: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(1); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL unmatched_fill_count: got %0d expected %0d", gotVal, expVal); end
  endtask

  // Fills on LCE1 (latency 9) and LCE3 (latency 8) in the same cycle
  task automatic test_multi_lce_max();
    $display("[TB] same-cycle latency candidates on LCE1 and LCE3");
    setReq(1, 40'h7000);
    tick();
    idle();
    setReq(3, 40'h8000);
    tick();
    idle();
    repeat (7) tick();
    expQ.push_back(64'd9);
    expQ.push_back(64'd1);
    expQ.push_back(64'd1);
    expQ.push_back(64'd0);
    setCmd(1, 40'h7000, 1'b1);
    setCmd(3, 40'h8000, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = 64'(max_latency); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL multi_max_latency: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(1); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL multi_fill_count1: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL multi_fill_count3: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(1) + outst(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL multi_outstanding: got %0d expected %0d", gotVal, expVal); end
  endtask

  // Timeout flag appears exactly Timeout cycles after accept; late fill
  // still matches and reports the capped latency
  task automatic test_timeout();
    $display("[TB] timeout on LCE0");
    setReq(0, 40'h300);
    tick();
    idle();
    repeat (14) tick();
    expQ.push_back(64'd0);
    tick();
    expVal = expQ.pop_front(); gotVal = 64'(err_timeout[0]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL timeout_early: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd1);
    tick();
    expVal = expQ.pop_front(); gotVal = 64'(err_timeout[0]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL timeout_flag: got %0d expected %0d", gotVal, expVal); end
    repeat (3) tick();
    expQ.push_back(64'd16);
    expQ.push_back(64'd0);
    expQ.push_back(64'd2);
    setCmd(0, 40'h300, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = 64'(max_latency); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL timeout_outstanding: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL timeout_fill_count: got %0d expected %0d", gotVal, expVal); end
  endtask

  // Five back-to-back requests on LCE2 with a four-entry table
  task automatic test_overflow();
    $display("[TB] overflow on LCE2");
    for (int k = 0; k < 5; k++) begin
      expQ.push_back(64'(k + 1));
      expQ.push_back(64'((k < MaxOut) ? k + 1 : MaxOut));
      expQ.push_back(64'((k < MaxOut) ? 0 : 1));
    end
    for (int k = 0; k < 5; k++) begin
      setReq(2, 40'h2000 + 40'(k * 64));
      tick();
      expVal = expQ.pop_front(); gotVal = reqCnt(2); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL overflow_req_count[%0d]: got %0d expected %0d", k, gotVal, expVal); end
      expVal = expQ.pop_front(); gotVal = outst(2); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL overflow_outstanding[%0d]: got %0d expected %0d", k, gotVal, expVal); end
      expVal = expQ.pop_front(); gotVal = 64'(err_overflow[2]); checkCount++;
      if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL overflow_flag[%0d]: got %0d expected %0d", k, gotVal, expVal); end
    end
    idle();
  endtask

  // Full LCE3 table: fill and request in the same cycle cannot reuse the slot
  task automatic test_back_to_back();
    $display("[TB] same-cycle fill and request on full LCE3");
    for (int k = 0; k < 4; k++) begin
      setReq(3, 40'h4000 + 40'(k * 64));
      tick();
    end
    idle();
    expQ.push_back(64'd4);
    expQ.push_back(64'd0);
    expVal = expQ.pop_front(); gotVal = outst(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_fill_table: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(err_overflow[3]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_no_early_overflow: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd3);
    expQ.push_back(64'd1);
    expQ.push_back(64'd2);
    expQ.push_back(64'd6);
    setCmd(3, 40'h4000, 1'b1);
    setReq(3, 40'h4100);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = outst(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_outstanding: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(err_overflow[3]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_overflow: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_fill_count: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = reqCnt(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_req_count: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd4);
    expQ.push_back(64'd0);
    setReq(3, 40'h4140);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = outst(3); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_reuse_outstanding: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[3]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL b2b_unmatched: got %0d expected %0d", gotVal, expVal); end
  endtask

  // Asynchronous reset drops tracking; clear keeps the table
  task automatic test_reset_and_clear();
    $display("[TB] mid-transaction reset and clear on LCE0");
    for (int k = 0; k < 3; k++) begin
      setReq(0, 40'h500 + 40'(k * 64));
      tick();
    end
    idle();
    expQ.push_back(64'd3);
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL rst_pre_outstanding: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    expVal = expQ.pop_front();
    gotVal = 64'(|{req_count, fill_count, outstanding, max_latency, err_timeout, err_overflow, err_unmatched});
    checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL async_reset_outputs: got %0d expected %0d", gotVal, expVal); end
    tick();
    reset_n = 1'b1;
    expQ.push_back(64'd1);
    expQ.push_back(64'd0);
    setCmd(0, 40'h500, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[0]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL rst_unmatched: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = fillCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL rst_fill_count: got %0d expected %0d", gotVal, expVal); end
    setReq(0, 40'h600);
    tick();
    idle();
    // Clear together with a new request: statistics zero, table still grows
    expQ.push_back(64'd0);
    expQ.push_back(64'd0);
    expQ.push_back(64'd2);
    clear = 1'b1;
    setReq(0, 40'h640);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = reqCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL clear_req_count: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[0]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL clear_unmatched: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL clear_outstanding: got %0d expected %0d", gotVal, expVal); end
    expQ.push_back(64'd1);
    expQ.push_back(64'd1);
    expQ.push_back(64'd2);
    expQ.push_back(64'd0);
    setCmd(0, 40'h600, 1'b1);
    tick();
    idle();
    expVal = expQ.pop_front(); gotVal = fillCnt(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL post_clear_fill_count: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = outst(0); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL post_clear_outstanding: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(max_latency); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL post_clear_latency: got %0d expected %0d", gotVal, expVal); end
    expVal = expQ.pop_front(); gotVal = 64'(err_unmatched[0]); checkCount++;
    if (gotVal !== expVal) begin errorCount++; $display("[TB] FAIL post_clear_unmatched: got %0d expected %0d", gotVal, expVal); end
  endtask

  // Scenario sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    test_reset();
    test_basic_fill();
    test_unmatched();
    test_multi_lce_max();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_and_clear();
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected %0d", expQ.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bp_me_lce_txn_monitor.md
Name: bp_me_lce_txn_monitor

Overview:
- Parametrised, multi-LCE successor to the per-LCE text tracer.
- Observes the LCE request and LCE command channels of num_lce_p LCEs in parallel.
- Tracks each outstanding miss request in a per-LCE table until the matching fill command arrives.
- Keeps saturating message counters and worst-case miss latency, and raises sticky error flags for timeout, table overflow and unmatched fills.
- Pure observer: sits beside the LCE-CCE network in ME testbenches and drives nothing back into the network.

Parameters:
- num_lce_p, 4, number of LCEs monitored.
- paddr_width_p, 40, physical address width.
- block_offset_bits_p, 6, low address bits ignored for block matching.
- max_outstanding_p, 4, tracking entries per LCE (>=1).
- timeout_cycles_p, 1024, age in cycles at which an entry is flagged (>=2).
- cnt_width_p, 32, width of saturating counters and the latency register.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of counters, latency and sticky errors; does not clear tables.
- req_v_i  in  num_lce_p  per-LCE request valid.
- req_ready_i  in  num_lce_p  per-LCE request ready.
- req_addr_i  in  num_lce_p*paddr_width_p  request address, LCE i at slice i.
- cmd_v_i  in  num_lce_p  per-LCE inbound command valid.
- cmd_yumi_i  in  num_lce_p  per-LCE command consumed.
- cmd_addr_i  in  num_lce_p*paddr_width_p  command address.
- cmd_fill_i  in  num_lce_p  command completes a miss (data or set-tag type).
- req_count_o  out  num_lce_p*cnt_width_p  accepted requests per LCE.
- fill_count_o  out  num_lce_p*cnt_width_p  matched fills per LCE.
- outstanding_o  out  num_lce_p*$clog2(max_outstanding_p+1)  valid entries per LCE.
- max_latency_o  out  cnt_width_p  largest matched miss latency, all LCEs.
- err_timeout_o  out  num_lce_p  sticky, per LCE.
- err_overflow_o  out  num_lce_p  sticky, per LCE.
- err_unmatched_o  out  num_lce_p  sticky, per LCE.

Behaviour:
- Reset (reset_n_i low, asynchronous assert): all entries invalid; all counters, max_latency_o and error flags 0; all outputs read 0. Deassertion is sampled at the next rising edge. Reset mid-transaction discards all tracking, with no error.
- Request accept: req_v_i[i] & req_ready_i[i] increments req_count[i] (saturates at all-ones) and allocates the lowest-index free entry of table i. The entry stores block address addr[paddr_width_p-1:block_offset_bits_p] with age = 0.
- Table full on accept: no allocation; err_overflow_o[i] set. The request is still counted.
- Age: every valid entry increments age by 1 per cycle, saturating at timeout_cycles_p.
- Timeout: when an entry's age reaches timeout_cycles_p-1, err_timeout_o[i] is set on the following edge. The entry stays valid and can still be matched later.
- Fill: cmd_v_i[i] & cmd_yumi_i[i] & cmd_fill_i[i] searches table i for valid entries whose block address is equal.
  - On a hit, the lowest matching index is freed, fill_count[i] increments, and latency = age+1.
  - If latency > max_latency_o, max_latency_o updates; ties do not update.
  - On a miss, err_unmatched_o[i] is set.
- Non-fill commands (cmd_fill_i=0) are ignored.
- Same-cycle request and fill on one LCE: the fill matches only entries valid before the edge, so a same-cycle request is never matched by that fill. Allocation uses the pre-edge free vector, so the freed slot is reusable only from the next cycle. Both updates commit on the same edge.
- Same-cycle max-latency candidates from several LCEs: the largest value wins.
- Duplicate block addresses in one table are legal; fills retire them lowest index first.
- clear_i (synchronous): zeroes counters, max_latency_o and sticky errors. Tables and ages are untouched. If an event occurs in the same cycle, clear wins for the counters and flags; table updates still occur.
- outstanding_o is a registered popcount of valid entries, updated on the same edge as the table.
- Latency: all outputs are registered; an event at edge N is visible after edge N.
- LCEs are fully independent, except for the shared max_latency_o.

Test Plan:
- Reset then LCE0 request addr 0x80_0000_0040, fill at the same block 5 cycles later -> req_count[0]=1, fill_count[0]=1, outstanding 1 then 0, max_latency_o=5, no errors.
- max_outstanding_p=4, 5 accepted requests on LCE2 with no fills -> outstanding_o[2]=4, err_overflow_o[2]=1, req_count[2]=5.
- Fill on LCE1 for addr 0x1000 with empty table -> err_unmatched_o[1]=1, fill_count[1]=0. A non-fill command to the same address -> no flag.
- timeout_cycles_p=16, request with no fill -> err_timeout_o set exactly 16 cycles after accept. A fill at cycle 20 -> latency 16 (saturated age+1), entry freed.
- Full table on LCE3: fill of entry 0 and a new request in the same cycle -> err_overflow_o[3]=1, outstanding 3. A request next cycle -> outstanding 4, no new error.
- Assert reset_n_i low mid-transaction with 3 outstanding -> outputs 0 immediately (asynchronous). After release, a fill -> unmatched error. Pulse clear_i -> flag cleared, table unchanged.
